stream_tracker: RTL
===================

// Module: stream_tracker
// PURPOSE
//  Parametrised, synthesisable transaction scoreboard for ASE CCI-P traffic. Records every
//  non-fence TX request per {channel, tid, cache-line}, retires on matching RX response,
//  flags unexpected/duplicate responses, tag reuse, table overflow and response timeouts.
//  Sits beside the ASE CCI-P bridge as a passive monitor; drives error/status only.
// PARAMETERS
//  NUM_CH       2     request/response channels tracked (c0/c1); CH_W = $clog2(NUM_CH)
//  DEPTH        64    scoreboard entries shared by all channels
//  TID_WIDTH    16    transaction-id width
//  MAX_CL       4     max cache lines per request (len field 0..MAX_CL-1)
//  TIMEOUT      4096  cycles before an incomplete entry is reported as timed out
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          async active-low reset
//  req_valid    in   1          TX request observed
//  req_ch       in   CH_W       channel of request
//  req_hdr      in   TxHdr_t    request header (reqtype, len)
//  req_tid      in   TID_WIDTH  request tid
//  rsp_valid    in   1          RX response observed
//  rsp_ch       in   CH_W       channel of response
//  rsp_hdr      in   RxHdr_t    response header (clnum)
//  rsp_tid      in   TID_WIDTH  response tid
//  err_valid    out  1          one-cycle error pulse
//  err_code     out  3          trk_err_e of pulsed error
//  err_ch       out  CH_W       channel of pulsed error
//  err_tid      out  TID_WIDTH  tid of pulsed error
//  err_sticky   out  4          OR of all errors since reset, one bit per class
//  outstanding  out  $clog2(DEPTH+1) valid entries
//  full         out  1          no free entry
// BEHAVIOUR
//  - Reset (async, rst_n=0): all entries invalid, all outputs 0. Reset mid-traffic discards
//    table silently; responses to pre-reset requests then report UNEXPECTED.
//  - Entry = {valid, ch, tid, pend[MAX_CL], age, timed_out}.
//  - Request, reqtype RDLINE_I/RDLINE_S: pend bits 0..len set. Other non-fence: pend bit [len]
//    only (write per-line index). WRFENCE: ignored, no entry, no error.
//  - Alloc: lowest-index free entry, visible next cycle. Entry freed this cycle not reusable
//    until next cycle. Table full -> OVERFLOW error, request dropped.
//  - Request whose {ch,tid} matches a valid entry -> DUP_TAG error, not allocated.
//  - Response: match valid entry with {ch,tid} and pend[clnum]=1 -> clear bit; pend==0 frees
//    entry. Entry present but pend[clnum]=0 -> DUP_RSP. No entry -> UNEXPECTED.
//  - Same-cycle req+rsp: response evaluated against pre-cycle table; rsp never matches the
//    request arriving in the same cycle (-> UNEXPECTED).
//  - Age: +1 per cycle while valid, saturating at TIMEOUT; on reaching TIMEOUT set timed_out,
//    raise TIMEOUT error once for that entry (lowest index wins if several; others pend,
//    reported on later free cycles). Timed-out entries still retire normally.
//  - Error outputs registered: pulse 1 cycle after the event. Same-cycle priority:
//    UNEXPECTED > DUP_RSP > DUP_TAG > OVERFLOW > TIMEOUT; losers still set err_sticky
//    (bits: 0 unexpected/dup_rsp, 1 dup_tag, 2 overflow, 3 timeout).
//  - outstanding/full registered, consistent with table after the edge.
//  - Widths: len/clnum are 2 bits; values >= MAX_CL on request/response -> UNEXPECTED, no update.
// STRUCTURE
//  - ase_pkg: typedef enum logic [2:0] trk_err_e {NONE, UNEXPECTED, DUP_RSP, DUP_TAG, OVERFLOW,
//    TIMEOUT}; trk_entry_t struct; TRK_STICKY_* bit constants.
//  - Sub-module stream_tracker_entry (x DEPTH): holds one entry, age counter, match/hit outputs.
//  - Top: free-slot priority encoder, match OR-reduction, error arbiter, counters.
// TESTING
//  - RDLINE_I ch0 tid=0x12 len=3; rsp clnum 3,0,2,1 -> no errors, outstanding 1->0 after 4th.
//  - WRLINE ch1 tid=0x5 len=2, rsp clnum=2 -> freed; second rsp same -> err UNEXPECTED, tid=0x5.
//  - Fill 64 entries, 65th req -> OVERFLOW pulse, full=1; one rsp frees, next-cycle req accepted.
//  - Req ch0 tid=7 twice -> DUP_TAG; req tid=7 on ch1 -> accepted (channels independent).
//  - TIMEOUT=16, req no rsp -> TIMEOUT pulse exactly 17 cycles after req, single pulse; late rsp ok.
//  - Rsp+UNEXPECTED and req overflow same cycle -> err_code UNEXPECTED, err_sticky=4'b0101;
//    assert rst_n mid-burst -> outputs 0 async, table empty.

Source files
------------

// File: rtl/stream_tracker_pkg.sv
// Shared types for the CCI-P transaction scoreboard: error codes, header views,
// entry layout and sticky-bit positions.
package stream_tracker_pkg;

    typedef enum logic [2:0] {
        TRK_NONE       = 3'd0,
        TRK_UNEXPECTED = 3'd1,
        TRK_DUP_RSP    = 3'd2,
        TRK_DUP_TAG    = 3'd3,
        TRK_OVERFLOW   = 3'd4,
        TRK_TIMEOUT    = 3'd5
    } trk_err_e;

    typedef enum logic [3:0] {
        REQ_WRLINE_I = 4'h0,
        REQ_WRLINE_M = 4'h1,
        REQ_WRPUSH_I = 4'h2,
        REQ_RDLINE_S = 4'h4,
        REQ_RDLINE_I = 4'h6,
        REQ_WRFENCE  = 4'h8
    } req_type_e;

    typedef struct packed {
        req_type_e   reqtype;
        logic [1:0]  len;
    } TxHdr_t;

    typedef struct packed {
        logic [1:0]  clnum;
    } RxHdr_t;

    // Entry layout at default parameters; handy when tracing a single slot.
    localparam int TRK_TID_W  = 16;
    localparam int TRK_MAX_CL = 4;
    localparam int TRK_AGE_W  = 13;

    typedef struct packed {
        logic                  valid;
        logic                  ch;
        logic [TRK_TID_W-1:0]  tid;
        logic [TRK_MAX_CL-1:0] pend;
        logic [TRK_AGE_W-1:0]  age;
        logic                  timed_out;
    } trk_entry_t;

    localparam int TRK_STICKY_UNEXP   = 0;
    localparam int TRK_STICKY_DUP_TAG = 1;
    localparam int TRK_STICKY_OVF     = 2;
    localparam int TRK_STICKY_TMO     = 3;

    // len/clnum are 2-bit fields; MAX_CL may be smaller than 4.
    function automatic logic cl_in_range(input logic [1:0] cl, input int max_cl);
        return int'(cl) < max_cl;
    endfunction

endpackage

// File: rtl/stream_tracker_if.sv
// Observed CCI-P request/response traffic plus the tracker's error reporting.
interface stream_tracker_if #(
    parameter int CH_W      = 1,
    parameter int TID_WIDTH = 16
);
    import stream_tracker_pkg::*;

    logic                 req_valid;
    logic [CH_W-1:0]      req_ch;
    TxHdr_t               req_hdr;
    logic [TID_WIDTH-1:0] req_tid;

    logic                 rsp_valid;
    logic [CH_W-1:0]      rsp_ch;
    RxHdr_t               rsp_hdr;
    logic [TID_WIDTH-1:0] rsp_tid;

    logic                 err_valid;
    trk_err_e             err_code;
    logic [CH_W-1:0]      err_ch;
    logic [TID_WIDTH-1:0] err_tid;
    logic [3:0]           err_sticky;

    modport master (
        output req_valid, req_ch, req_hdr, req_tid,
        output rsp_valid, rsp_ch, rsp_hdr, rsp_tid,
        input  err_valid, err_code, err_ch, err_tid, err_sticky
    );

    modport slave (
        input  req_valid, req_ch, req_hdr, req_tid,
        input  rsp_valid, rsp_ch, rsp_hdr, rsp_tid,
        output err_valid, err_code, err_ch, err_tid, err_sticky
    );

endinterface

// File: rtl/stream_tracker_entry.sv
// One scoreboard slot: {ch, tid, pending lines, age}; reports request/response
// matches and a one-shot timeout request to the top-level arbiter.
module stream_tracker_entry #(
    parameter int CH_W      = 1,
    parameter int TID_WIDTH = 16,
    parameter int MAX_CL    = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc,
    input  logic [CH_W-1:0]      req_ch,
    input  logic [TID_WIDTH-1:0] req_tid,
    input  logic [MAX_CL-1:0]    load_pend,
    input  logic [CH_W-1:0]      rsp_ch,
    input  logic [TID_WIDTH-1:0] rsp_tid,
    input  logic [1:0]           rsp_cl,
    input  logic                 rsp_clr,
    input  logic                 tmo_ack,
    output logic                 valid,
    output logic [CH_W-1:0]      ch,
    output logic [TID_WIDTH-1:0] tid,
    output logic                 req_match,
    output logic                 rsp_match,
    output logic                 rsp_hit,
    output logic                 rsp_last,
    output logic                 tmo_hit
);
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    logic [MAX_CL-1:0] pend;
    logic [MAX_CL-1:0] cl_mask;
    logic [AGE_W-1:0]  age;
    logic              reported;
    logic              timed_out;

    // Out-of-range clnum shifts the bit out, so it can never hit.
    assign cl_mask   = MAX_CL'(1) << rsp_cl;
    assign req_match = valid && (ch == req_ch) && (tid == req_tid);
    assign rsp_match = valid && (ch == rsp_ch) && (tid == rsp_tid);
    assign rsp_hit   = rsp_match && |(pend & cl_mask);
    assign rsp_last  = rsp_hit && ((pend & ~cl_mask) == '0);
    assign timed_out = (age == AGE_W'(TIMEOUT));
    assign tmo_hit   = valid && timed_out && !reported;

    // Slot state: load on alloc, age while live, retire when last line returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            ch       <= '0;
            tid      <= '0;
            pend     <= '0;
            age      <= '0;
            reported <= 1'b0;
        end else if (alloc) begin
            valid    <= 1'b1;
            ch       <= req_ch;
            tid      <= req_tid;
            pend     <= load_pend;
            age      <= '0;
            reported <= 1'b0;
        end else if (valid) begin
            if (!timed_out) age <= age + AGE_W'(1);
            if (tmo_ack) reported <= 1'b1;
            if (rsp_clr && rsp_hit) begin
                pend <= pend & ~cl_mask;
                if ((pend & ~cl_mask) == '0) valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_tracker.sv
// Passive CCI-P scoreboard: allocates a slot per non-fence request, retires it
// as responses return, and reports protocol errors and timeouts.
module stream_tracker
    import stream_tracker_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 64,
    parameter int TID_WIDTH = 16,
    parameter int MAX_CL    = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    stream_tracker_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       full
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     ent_valid, ent_req_match, ent_rsp_match;
    logic [DEPTH-1:0]     ent_rsp_hit, ent_rsp_last, ent_tmo;
    logic [DEPTH-1:0]     free_vec, free_lsb, tmo_lsb, alloc_sel, tmo_ack;
    logic [CH_W-1:0]      ent_ch  [DEPTH];
    logic [TID_WIDTH-1:0] ent_tid [DEPTH];
    logic [MAX_CL-1:0]    new_pend;
    logic                 is_rd, req_live, req_cl_ok, rsp_cl_ok, rsp_apply;
    logic                 req_unexp, req_dup, req_ovf, alloc_do;
    logic                 rsp_unexp, rsp_dup, free_do, tmo_win;
    logic [CH_W-1:0]      tmo_ch, err_ch_nxt;
    logic [TID_WIDTH-1:0] tmo_tid, err_tid_nxt;
    trk_err_e             err_nxt;
    logic [3:0]           sticky_set;
    logic [CNT_W-1:0]     cnt_nxt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        stream_tracker_entry #(
            .CH_W(CH_W), .TID_WIDTH(TID_WIDTH), .MAX_CL(MAX_CL), .TIMEOUT(TIMEOUT)
        ) u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .alloc     (alloc_sel[i]),
            .req_ch    (bus.req_ch),
            .req_tid   (bus.req_tid),
            .load_pend (new_pend),
            .rsp_ch    (bus.rsp_ch),
            .rsp_tid   (bus.rsp_tid),
            .rsp_cl    (bus.rsp_hdr.clnum),
            .rsp_clr   (rsp_apply),
            .tmo_ack   (tmo_ack[i]),
            .valid     (ent_valid[i]),
            .ch        (ent_ch[i]),
            .tid       (ent_tid[i]),
            .req_match (ent_req_match[i]),
            .rsp_match (ent_rsp_match[i]),
            .rsp_hit   (ent_rsp_hit[i]),
            .rsp_last  (ent_rsp_last[i]),
            .tmo_hit   (ent_tmo[i])
        );
    end

    // Lowest-index free slot and lowest-index timed-out slot (isolate lowest set bit).
    assign free_vec = ~ent_valid;
    assign free_lsb = free_vec & (~free_vec + DEPTH'(1));
    assign tmo_lsb  = ent_tmo & (~ent_tmo + DEPTH'(1));

    assign is_rd     = (bus.req_hdr.reqtype == REQ_RDLINE_I) || (bus.req_hdr.reqtype == REQ_RDLINE_S);
    assign req_live  = bus.req_valid && (bus.req_hdr.reqtype != REQ_WRFENCE);
    assign req_cl_ok = cl_in_range(bus.req_hdr.len, MAX_CL);
    assign req_unexp = req_live && !req_cl_ok;
    assign req_dup   = req_live && req_cl_ok && |ent_req_match;
    assign req_ovf   = req_live && req_cl_ok && !(|ent_req_match) && !(|free_vec);
    assign alloc_do  = req_live && req_cl_ok && !(|ent_req_match) && |free_vec;
    assign alloc_sel = alloc_do ? free_lsb : '0;

    // Responses see only the pre-edge table, so a same-cycle request never matches.
    assign rsp_cl_ok = cl_in_range(bus.rsp_hdr.clnum, MAX_CL);
    assign rsp_apply = bus.rsp_valid && rsp_cl_ok;
    assign rsp_unexp = bus.rsp_valid && (!rsp_cl_ok || !(|ent_rsp_match));
    assign rsp_dup   = rsp_apply && |ent_rsp_match && !(|ent_rsp_hit);
    assign free_do   = rsp_apply && |ent_rsp_last;

    assign tmo_ack = tmo_win ? tmo_lsb : '0;
    assign cnt_nxt = outstanding + CNT_W'(alloc_do) - CNT_W'(free_do);

    // Reads expect every line up to len; writes carry one per-line index.
    always_comb begin
        new_pend = '0;
        for (int k = 0; k < MAX_CL; k++) begin
            if (is_rd) new_pend[k] = (k <= int'(bus.req_hdr.len));
            else       new_pend[k] = (k == int'(bus.req_hdr.len));
        end
    end

    // Identify the slot whose timeout is being reported.
    always_comb begin
        tmo_ch  = '0;
        tmo_tid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tmo_lsb[i]) begin
                tmo_ch  = ent_ch[i];
                tmo_tid = ent_tid[i];
            end
        end
    end

    // Error arbitration; a timeout only reports on a cycle with no other error.
    always_comb begin
        err_nxt     = TRK_NONE;
        err_ch_nxt  = '0;
        err_tid_nxt = '0;
        tmo_win     = 1'b0;
        if (rsp_unexp) begin
            err_nxt = TRK_UNEXPECTED; err_ch_nxt = bus.rsp_ch; err_tid_nxt = bus.rsp_tid;
        end else if (req_unexp) begin
            err_nxt = TRK_UNEXPECTED; err_ch_nxt = bus.req_ch; err_tid_nxt = bus.req_tid;
        end else if (rsp_dup) begin
            err_nxt = TRK_DUP_RSP; err_ch_nxt = bus.rsp_ch; err_tid_nxt = bus.rsp_tid;
        end else if (req_dup) begin
            err_nxt = TRK_DUP_TAG; err_ch_nxt = bus.req_ch; err_tid_nxt = bus.req_tid;
        end else if (req_ovf) begin
            err_nxt = TRK_OVERFLOW; err_ch_nxt = bus.req_ch; err_tid_nxt = bus.req_tid;
        end else if (|ent_tmo) begin
            err_nxt = TRK_TIMEOUT; err_ch_nxt = tmo_ch; err_tid_nxt = tmo_tid; tmo_win = 1'b1;
        end
    end

    // Every error class seen this cycle lands in the sticky vector, winner or not.
    always_comb begin
        sticky_set = '0;
        sticky_set[TRK_STICKY_UNEXP]   = rsp_unexp | req_unexp | rsp_dup;
        sticky_set[TRK_STICKY_DUP_TAG] = req_dup;
        sticky_set[TRK_STICKY_OVF]     = req_ovf;
        sticky_set[TRK_STICKY_TMO]     = |ent_tmo;
    end

    // Registered error and occupancy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_valid  <= 1'b0;
            bus.err_code   <= TRK_NONE;
            bus.err_ch     <= '0;
            bus.err_tid    <= '0;
            bus.err_sticky <= '0;
            outstanding    <= '0;
            full           <= 1'b0;
        end else begin
            bus.err_valid  <= (err_nxt != TRK_NONE);
            bus.err_code   <= err_nxt;
            bus.err_ch     <= err_ch_nxt;
            bus.err_tid    <= err_tid_nxt;
            bus.err_sticky <= bus.err_sticky | sticky_set;
            outstanding    <= cnt_nxt;
            full           <= (cnt_nxt == CNT_W'(DEPTH));
        end
    end

endmodule
